// File: rtl/rv_pkg.sv
// Shared RISC-V front-end types and constants.
// XLEN/ILEN fix the datapath widths of every fetch-side block; fetch_entry_t
// is the {pc, instr} pair handed from fetch to decode.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // Canonical NOP (addi x0, x0, 0), used by downstream stages for bubbles.
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Clears the byte-offset bits of a PC; instruction memory is word-aligned.
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(3);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetch_entry_t between the fetch datapath and decode.
// Push and pop in the same cycle are legal at any occupancy, including full:
// the popped head slot is the one the push lands in, so occupancy is unchanged.
// flush_i empties the FIFO without clearing the storage.
module fetch_buf
    import rv_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [1:0]   occ_o
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_occ;

    logic         w_push;
    logic         w_pop;

    // A push into a full FIFO is only honoured when the head leaves the same cycle;
    // a pop from an empty FIFO is ignored.
    always_comb begin
        w_pop  = pop_i & (r_occ != 2'd0);
        w_push = push_i & ((r_occ != 2'd2) | w_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else if (flush_i) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign head_o = r_mem[r_rd_ptr];
    assign occ_o  = r_occ;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage.
// Owns the PC, drives the word-aligned instruction memory read port, hides the
// memory's one-cycle registered read latency and hands {pc, instr} to decode.
//
// Handshake: instr_valid_o/instr_o/instr_pc_o describe the head instruction;
// a transfer happens in any cycle where instr_valid_o & instr_ready_i. While
// valid is high and ready is low the head is held stable until it transfers
// or a redirect/reset discards it.
//
// Datapath widths come from rv_pkg::XLEN. Optional feature: define
// IFETCH_PERF_EN to add the perf_fetched_o / perf_stall_o counters.
module ifetch
    import rv_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [XLEN-1:0]   instr_o,
    output logic [XLEN-1:0]   instr_pc_o,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched_o,
    output logic [31:0]       perf_stall_o
`endif
);

    logic [XLEN-1:0] r_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;

    fetch_entry_t    w_buf_head;
    fetch_entry_t    w_push_data;
    logic [1:0]      w_occ;
    logic            w_has_entry;
    logic            w_valid;
    logic            w_pop;
    logic [2:0]      w_load;
    logic            w_issue;
    logic            w_push;
    logic            w_buf_pop;

    // Handshake, issue rule and buffer control.
    // The issue decision depends on instr_ready_i in the same cycle, so a word
    // leaving this cycle frees room for the read being launched now.
    always_comb begin
        w_has_entry = (w_occ != 2'd0);
        w_valid     = ~redirect_i & (w_has_entry | r_inflight);
        w_pop       = w_valid & instr_ready_i;
        w_load      = {1'b0, w_occ} + {2'b00, r_inflight};
        w_issue     = ~redirect_i & (w_load <= (3'd1 + {2'b00, w_pop}));
        // Older buffered entries always leave first; the in-flight word only
        // bypasses when the buffer is empty. Otherwise it queues behind them.
        w_buf_pop   = w_pop & w_has_entry;
        w_push      = r_inflight & ~redirect_i & ~(w_pop & ~w_has_entry);
        w_push_data = '{pc: r_inflight_pc, instr: mem_rdata_i};
    end

    // Output head: buffer first, then the word arriving from memory this cycle.
    always_comb begin
        instr_o    = '0;
        instr_pc_o = '0;
        if (w_has_entry) begin
            instr_o    = w_buf_head.instr;
            instr_pc_o = w_buf_head.pc;
        end else if (r_inflight) begin
            instr_o    = mem_rdata_i;
            instr_pc_o = r_inflight_pc;
        end
    end

    assign instr_valid_o = w_valid;
    // Memory reads pc_q every cycle; the result only matters when a read was issued.
    assign mem_raddr_o   = ADDR_W'(r_pc >> 2);

    // PC and in-flight tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_i) begin
            r_pc       <= redirect_pc_i & PC_ALIGN_MASK;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_pc          <= r_pc + XLEN'(4);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    fetch_buf u_fetch_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_buf_pop),
        .flush_i     (redirect_i),
        .head_o      (w_buf_head),
        .occ_o       (w_occ)
    );

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    // Transfer and back-pressure counters; valid is forced low on redirect
    // cycles, so those cycles never count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_valid & ~instr_ready_i) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_stall_o   = r_perf_stall;
`endif

endmodule
